// File: rtl/riscv_pkg.sv
// riscv: shared rename-stage parameters and types
package riscv;
  localparam int FRONTEND_WIDTH = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int PHYS_REGS_ADDR_SIZE = $clog2(PHYS_REGS);
  typedef logic [4:0] areg_t;
  typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;
  typedef struct packed {
    preg_t prd;
    preg_t old_prd;
    preg_t prs1;
    preg_t prs2;
  } rename_slot_t;
endpackage

// File: rtl/rat_bypass.sv
// rat_bypass: per-slot intra-group source and old-destination bypass
module rat_bypass import riscv::*; #(
  parameter int FW = FRONTEND_WIDTH
) (
  input  logic [FW-1:0]         wr,
  input  areg_t [FW-1:0]        rd,
  input  logic [FW-1:0]         rs1_v,
  input  areg_t [FW-1:0]        rs1,
  input  logic [FW-1:0]         rs2_v,
  input  areg_t [FW-1:0]        rs2,
  input  preg_t [FW-1:0]        new_prd,
  input  preg_t [FW-1:0]        rat_rs1,
  input  preg_t [FW-1:0]        rat_rs2,
  input  preg_t [FW-1:0]        rat_rd,
  output rename_slot_t [FW-1:0] slot
);
  always_comb begin
    for (int s = 0; s < FW; s++) begin
      slot[s].prd = new_prd[s];
      slot[s].old_prd = rat_rd[s];
      slot[s].prs1 = rat_rs1[s];
      slot[s].prs2 = rat_rs2[s];
      for (int j = 0; j < s; j++) begin
        if (wr[j] && rd[j] == rs1[s]) slot[s].prs1 = new_prd[j];
        if (wr[j] && rd[j] == rs2[s]) slot[s].prs2 = new_prd[j];
        if (wr[j] && rd[j] == rd[s]) slot[s].old_prd = new_prd[j];
      end
      slot[s].prs1 = (rs1_v[s] && rs1[s] != '0) ? slot[s].prs1 : '0;
      slot[s].prs2 = (rs2_v[s] && rs2[s] != '0) ? slot[s].prs2 : '0;
      slot[s].old_prd = wr[s] ? slot[s].old_prd : '0;
    end
  end
endmodule

// File: rtl/rename_rat.sv
// rename_rat: speculative/committed RAT rename stage with one output register
module rename_rat import riscv::*; #(
  parameter int FW = FRONTEND_WIDTH,
  parameter int CW = COMMIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dec_valid_i,
  output logic                     rename_ready_o,
  input  logic [FW-1:0]            dec_rd_v_i,
  input  areg_t [FW-1:0]           dec_rd_i,
  input  logic [FW-1:0]            dec_rs1_v_i,
  input  areg_t [FW-1:0]           dec_rs1_i,
  input  logic [FW-1:0]            dec_rs2_v_i,
  input  areg_t [FW-1:0]           dec_rs2_i,
  input  preg_t [FW-1:0]           freelist_preg_i,
  input  logic [$clog2(FW+1)-1:0]  freelist_avail_i,
  output logic [$clog2(FW+1)-1:0]  freelist_pop_o,
  input  logic [CW-1:0]            commit_v_i,
  input  areg_t [CW-1:0]           commit_rd_i,
  input  preg_t [CW-1:0]           commit_prd_i,
  input  logic                     flush_i,
  output logic                     dispatch_valid_o,
  input  logic                     dispatch_ready_i,
  output preg_t [FW-1:0]           dispatch_prd_o,
  output preg_t [FW-1:0]           dispatch_old_prd_o,
  output preg_t [FW-1:0]           dispatch_prs1_o,
  output preg_t [FW-1:0]           dispatch_prs2_o
);
  localparam int NW = $clog2(FW+1);
  preg_t spec_rat [ARCH_REGS];
  preg_t commit_rat [ARCH_REGS];
  preg_t commit_nxt [ARCH_REGS];
  logic [FW-1:0] wr;
  preg_t [FW-1:0] new_prd;
  preg_t [FW-1:0] rat_rs1;
  preg_t [FW-1:0] rat_rs2;
  preg_t [FW-1:0] rat_rd;
  rename_slot_t [FW-1:0] slot;
  rename_slot_t [FW-1:0] out_q;
  logic [NW-1:0] need;
  logic accept;
  int cnt;
  always_comb begin
    cnt = 0;
    for (int s = 0; s < FW; s++) begin
      wr[s] = dec_rd_v_i[s] && dec_rd_i[s] != '0;
      new_prd[s] = '0;
      for (int w = 0; w < FW; w++) if (wr[s] && w == cnt) new_prd[s] = freelist_preg_i[w];
      cnt = cnt + (wr[s] ? 1 : 0);
      rat_rs1[s] = spec_rat[dec_rs1_i[s]];
      rat_rs2[s] = spec_rat[dec_rs2_i[s]];
      rat_rd[s] = spec_rat[dec_rd_i[s]];
    end
    need = NW'(cnt);
    rename_ready_o = !flush_i && (!dispatch_valid_o || dispatch_ready_i) && freelist_avail_i >= need;
    accept = dec_valid_i && rename_ready_o;
    freelist_pop_o = accept ? need : '0;
  end
  always_comb begin
    commit_nxt = commit_rat;
    for (int c = 0; c < CW; c++) if (commit_v_i[c] && commit_rd_i[c] != '0) commit_nxt[commit_rd_i[c]] = commit_prd_i[c];
  end
  rat_bypass #(.FW(FW)) u_bypass (
    .wr(wr),
    .rd(dec_rd_i),
    .rs1_v(dec_rs1_v_i),
    .rs1(dec_rs1_i),
    .rs2_v(dec_rs2_v_i),
    .rs2(dec_rs2_i),
    .new_prd(new_prd),
    .rat_rs1(rat_rs1),
    .rat_rs2(rat_rs2),
    .rat_rd(rat_rd),
    .slot(slot)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= preg_t'(i);
        commit_rat[i] <= preg_t'(i);
      end
      dispatch_valid_o <= 1'b0;
      out_q <= '0;
    end else begin
      commit_rat <= commit_nxt;
      if (flush_i) spec_rat <= commit_nxt;
      else if (accept) for (int s = 0; s < FW; s++) if (wr[s]) spec_rat[dec_rd_i[s]] <= new_prd[s];
      if (flush_i) dispatch_valid_o <= 1'b0;
      else if (accept) begin
        dispatch_valid_o <= 1'b1;
        out_q <= slot;
      end else if (dispatch_ready_i) dispatch_valid_o <= 1'b0;
    end
  end
  always_comb begin
    for (int s = 0; s < FW; s++) begin
      dispatch_prd_o[s] = out_q[s].prd;
      dispatch_old_prd_o[s] = out_q[s].old_prd;
      dispatch_prs1_o[s] = out_q[s].prs1;
      dispatch_prs2_o[s] = out_q[s].prs2;
    end
  end
endmodule
